// File: rtl/enigma_pkg.sv
// Shared constants for the programmable reflector: default widths, the UKW-B
// wiring used as reset contents, and the commit FSM state encoding.
package enigma_pkg;

  localparam int ALPHA_W_DEF   = 5;
  localparam int N_SYMBOLS_DEF = 26;
  localparam int UKW_B_LEN     = 26;

  // AY BR CU DH EQ FS GL IP JX KN MO TZ VW
  localparam int unsigned UKW_B [UKW_B_LEN] = '{
    24, 17, 20, 7, 16, 18, 11, 3, 15, 23, 13, 6, 14,
    10, 12, 8, 4, 1, 5, 25, 2, 22, 21, 9, 0, 19
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_COPY  = 2'd2
  } cfg_state_e;

  // Symbols beyond the historical alphabet reset to themselves.
  function automatic int unsigned ukw_b_at(input int unsigned idx);
    int unsigned val;
    val = idx;
    if (idx < UKW_B_LEN) val = UKW_B[idx];
    return val;
  endfunction

endpackage

// File: rtl/reflector_checker.sv
// Shadow wiring table with pairwise writes, plus the check-and-commit sequencer
// that verifies the table is an involution before strobing a copy into a bank.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | accepts pair writes and cfg_commit
// ST_CHECK | tests one symbol per cycle; any failure is sticky
// ST_COPY  | single cycle, copy_en high, target bank loads the shadow
module reflector_checker
  import enigma_pkg::*;
#(
  parameter int ALPHA_W     = ALPHA_W_DEF,
  parameter int N_SYMBOLS   = N_SYMBOLS_DEF,
  parameter int BANK_W      = 2,
  parameter int ALLOW_FIXED = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_wr,
  input  logic [ALPHA_W-1:0]             cfg_a,
  input  logic [ALPHA_W-1:0]             cfg_b,
  input  logic                           cfg_commit,
  input  logic [BANK_W-1:0]              cfg_bank,
  output logic                           cfg_busy,
  output logic                           cfg_done,
  output logic                           cfg_err,
  output logic [N_SYMBOLS*ALPHA_W-1:0]   shadow_flat,
  output logic                           copy_en,
  output logic [BANK_W-1:0]              copy_bank
);

  localparam logic [ALPHA_W:0]   N_SYM_W  = (ALPHA_W+1)'(N_SYMBOLS);
  localparam logic [ALPHA_W-1:0] LAST_IDX = ALPHA_W'(N_SYMBOLS - 1);

  cfg_state_e         state_q, state_d;
  logic [ALPHA_W-1:0] shadow [N_SYMBOLS];
  logic [ALPHA_W-1:0] idx_q;
  logic               fail_q;
  logic [BANK_W-1:0]  bank_q;
  logic [ALPHA_W-1:0] partner, partner_back;
  logic               fail_idx, last_idx, fail_any, wr_ok;

  assign partner      = shadow[idx_q];
  assign partner_back = shadow[partner];
  assign fail_idx     = (partner_back != idx_q) || ((ALLOW_FIXED == 0) && (partner == idx_q));
  assign last_idx     = (idx_q == LAST_IDX);
  assign fail_any     = fail_q || fail_idx;
  assign wr_ok        = (state_q == ST_IDLE) && cfg_wr && !cfg_commit &&
                        ({1'b0, cfg_a} < N_SYM_W) && ({1'b0, cfg_b} < N_SYM_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_commit) state_d = ST_CHECK;
      ST_CHECK: if (last_idx) state_d = fail_any ? ST_IDLE : ST_COPY;
      ST_COPY:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      fail_q   <= 1'b0;
      bank_q   <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_commit) begin
            bank_q <= cfg_bank;
            idx_q  <= '0;
            fail_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          idx_q  <= idx_q + ALPHA_W'(1);
          fail_q <= fail_any;
          if (last_idx && fail_any) begin
            cfg_done <= 1'b1;
            cfg_err  <= 1'b1;
          end
        end
        ST_COPY: cfg_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // A pair write never clears an old partner; the check rejects stale links.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SYMBOLS; i++) shadow[i] <= ALPHA_W'(ukw_b_at(i));
    end else if (wr_ok) begin
      for (int i = 0; i < N_SYMBOLS; i++) begin
        if (ALPHA_W'(i) == cfg_a)      shadow[i] <= cfg_b;
        else if (ALPHA_W'(i) == cfg_b) shadow[i] <= cfg_a;
      end
    end
  end

  for (genvar g = 0; g < N_SYMBOLS; g++) begin : g_flat
    assign shadow_flat[g*ALPHA_W +: ALPHA_W] = shadow[g];
  end

  assign cfg_busy  = (state_q != ST_IDLE);
  assign copy_en   = (state_q == ST_COPY);
  assign copy_bank = bank_q;

endmodule

// File: rtl/reflector_prog.sv
// Multi-bank programmable reflector: bank registers and a one-deep valid/ready
// lookup stage; reprogramming is delegated to reflector_checker.
module reflector_prog
  import enigma_pkg::*;
#(
  parameter int   ALPHA_W     = ALPHA_W_DEF,
  parameter int   N_SYMBOLS   = N_SYMBOLS_DEF,
  parameter int   N_BANKS     = 4,
  parameter int   ALLOW_FIXED = 0,
  localparam int  BANK_W      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALPHA_W-1:0] data_in,
  input  logic [BANK_W-1:0]  bank_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALPHA_W-1:0] data_out,
  output logic               out_err,
  input  logic               cfg_wr,
  input  logic [ALPHA_W-1:0] cfg_a,
  input  logic [ALPHA_W-1:0] cfg_b,
  input  logic               cfg_commit,
  input  logic [BANK_W-1:0]  cfg_bank,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam logic [ALPHA_W:0] N_SYM_W = (ALPHA_W+1)'(N_SYMBOLS);

  logic [ALPHA_W-1:0]           bank [N_BANKS][N_SYMBOLS];
  logic [N_SYMBOLS*ALPHA_W-1:0] shadow_flat;
  logic                         copy_en;
  logic [BANK_W-1:0]            copy_bank;
  logic                         in_range, accept;
  logic [ALPHA_W-1:0]           safe_idx, look_val;

  reflector_checker #(
    .ALPHA_W     (ALPHA_W),
    .N_SYMBOLS   (N_SYMBOLS),
    .BANK_W      (BANK_W),
    .ALLOW_FIXED (ALLOW_FIXED)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_wr      (cfg_wr),
    .cfg_a       (cfg_a),
    .cfg_b       (cfg_b),
    .cfg_commit  (cfg_commit),
    .cfg_bank    (cfg_bank),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .shadow_flat (shadow_flat),
    .copy_en     (copy_en),
    .copy_bank   (copy_bank)
  );

  // A lookup accepted on the copy edge still reads the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANKS; b++)
        for (int i = 0; i < N_SYMBOLS; i++)
          bank[b][i] <= ALPHA_W'(ukw_b_at(i));
    end else if (copy_en) begin
      for (int i = 0; i < N_SYMBOLS; i++)
        bank[copy_bank][i] <= shadow_flat[i*ALPHA_W +: ALPHA_W];
    end
  end

  assign in_range = ({1'b0, data_in} < N_SYM_W);
  assign safe_idx = in_range ? data_in : '0;
  assign look_val = in_range ? bank[bank_sel][safe_idx] : data_in;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_out  <= look_val;
      out_err   <= !in_range;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reflector_prog.sv
// Bench for reflector_prog: directed steps plus random traffic, compared each
// cycle against a table-level reference model (one DUT strict, one fixed-point).
module tb_reflector_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, out_ready, cfg_wr, cfg_commit;
  logic [4:0] data_in, cfg_a, cfg_b;
  logic [1:0] bank_sel, cfg_bank;

  logic       in_ready, out_valid, out_err, cfg_busy, cfg_done, cfg_err;
  logic [4:0] data_out;
  logic       f_in_ready, f_out_valid, f_out_err, f_cfg_busy, f_cfg_done, f_cfg_err;
  logic [4:0] f_data_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reflector_prog #(.ALLOW_FIXED(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .bank_sel(bank_sel), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .out_err(out_err),
    .cfg_wr(cfg_wr), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_commit(cfg_commit),
    .cfg_bank(cfg_bank), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  reflector_prog #(.ALLOW_FIXED(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
    .data_in(data_in), .bank_sel(bank_sel), .out_valid(f_out_valid),
    .out_ready(out_ready), .data_out(f_data_out), .out_err(f_out_err),
    .cfg_wr(cfg_wr), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_commit(cfg_commit),
    .cfg_bank(cfg_bank), .cfg_busy(f_cfg_busy), .cfg_done(f_cfg_done), .cfg_err(f_cfg_err)
  );

  // Reference wiring from the letter pairs AY BR CU DH EQ FS GL IP JX KN MO TZ VW
  int ukw[26] = '{24, 17, 20, 7, 16, 18, 11, 3, 15, 23, 13, 6, 14,
                  10, 12, 8, 4, 1, 5, 25, 2, 22, 21, 9, 0, 19};

  int m_bank[4][26];
  int m_sh[2][26];
  bit m_valid, m_oerr;
  int m_data;
  int m_left[2], m_cb[2];
  bit m_pass[2], m_done[2], m_cerr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit inv_ok(input int k, input bit allow);
    for (int x = 0; x < 26; x++) begin
      int y;
      y = m_sh[k][x];
      if (m_sh[k][y] != x || (!allow && y == x)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 26; i++) m_bank[b][i] = ukw[i];
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 26; i++) m_sh[k][i] = ukw[i];
      m_left[k] = 0; m_done[k] = 0; m_cerr[k] = 0; m_pass[k] = 0; m_cb[k] = 0;
    end
    m_valid = 0; m_oerr = 0; m_data = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; data_in = 0; bank_sel = 0; out_ready = 1;
    cfg_wr = 0; cfg_a = 0; cfg_b = 0; cfg_commit = 0; cfg_bank = 0;
  endtask

  // One clock: predict from current inputs, advance, compare every output.
  task automatic cycle();
    bit acc, nv, ne;
    int nd;
    acc = in_valid && (!m_valid || out_ready);
    nv = m_valid; nd = m_data; ne = m_oerr;
    if (acc) begin
      nv = 1;
      if (int'(data_in) >= 26) begin nd = int'(data_in); ne = 1; end
      else begin nd = m_bank[bank_sel][data_in]; ne = 0; end
    end else if (out_ready) nv = 0;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0; m_cerr[k] = 0;
      if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_done[k] = 1;
          m_cerr[k] = !m_pass[k];
          if (k == 0 && m_pass[k])
            for (int i = 0; i < 26; i++) m_bank[m_cb[k]][i] = m_sh[k][i];
        end
      end else if (cfg_commit) begin
        m_pass[k] = inv_ok(k, k == 1);
        m_left[k] = m_pass[k] ? 27 : 26;
        m_cb[k] = int'(cfg_bank);
      end else if (cfg_wr && cfg_a < 26 && cfg_b < 26) begin
        m_sh[k][cfg_a] = int'(cfg_b);
        m_sh[k][cfg_b] = int'(cfg_a);
      end
    end
    @(posedge clk); #1;
    m_valid = nv; m_data = nd; m_oerr = ne;
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_valid", out_valid, m_valid);
    chk("data_out", data_out, m_data);
    chk("out_err", out_err, m_oerr);
    chk("cfg_busy", cfg_busy, m_left[0] > 0);
    chk("cfg_done", cfg_done, m_done[0]);
    chk("cfg_err", cfg_err, m_cerr[0]);
    chk("fx_cfg_busy", f_cfg_busy, m_left[1] > 0);
    chk("fx_cfg_done", f_cfg_done, m_done[1]);
    chk("fx_cfg_err", f_cfg_err, m_cerr[1]);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic wr(input int a, input int b);
    cfg_wr = 1; cfg_a = 5'(a); cfg_b = 5'(b);
    cycle();
    cfg_wr = 0;
  endtask

  task automatic commit(input int bk);
    cfg_commit = 1; cfg_bank = 2'(bk);
    cycle();
    cfg_commit = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      if (m_left[0] == 0 && m_left[1] == 0) break;
      cycle();
    end
    chk("commit_finished", (m_left[0] == 0 && m_left[1] == 0), 1);
  endtask

  task automatic sweep(input int bk);
    out_ready = 1; bank_sel = 2'(bk);
    for (int i = 0; i < 26; i++) begin
      in_valid = 1; data_in = 5'(i);
      cycle();
    end
    in_valid = 0;
    cycle();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #3;
    do_reset();

    // 1: UKW-B in bank 0
    sweep(0);

    // 2: out-of-range symbol, then backpressure
    in_valid = 1; data_in = 5'd30; bank_sel = 0; out_ready = 1;
    cycle();
    chk("oor_value", data_out, 30);
    chk("oor_err", out_err, 1);
    data_in = 5'd5; out_ready = 0;
    repeat (3) cycle();
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1;
    cycle();
    in_valid = 0;
    cycle();

    // 3: stale pairs must fail; bank 1 unchanged
    wr(0, 25); wr(1, 24); wr(24, 25);
    commit(1);
    wait_idle();
    sweep(1);

    // 4: full UKW-C into bank 2
    wr(0, 5); wr(1, 21); wr(2, 15); wr(3, 9); wr(4, 8); wr(6, 14); wr(7, 24);
    wr(10, 17); wr(11, 25); wr(12, 23); wr(13, 22); wr(16, 19); wr(18, 20);
    commit(2);
    wait_idle();
    in_valid = 1; data_in = 0; bank_sel = 2;
    cycle();
    chk("ukwc_lookup_a", data_out, 5);
    in_valid = 0;
    sweep(2);

    // 5: swap two pairs, commit while streaming lookups; extra commit is ignored
    wr(0, 1); wr(5, 21);
    commit(2);
    in_valid = 1; data_in = 0; bank_sel = 2; out_ready = 1;
    for (int n = 0; n < 32; n++) begin
      cfg_commit = (n == 6); cfg_bank = 2'd3;
      cycle();
    end
    cfg_commit = 0; in_valid = 0;
    cycle();

    // 6: fixed points
    wr(14, 14);
    commit(3);
    wait_idle();
    do_reset();
    wr(14, 14); wr(13, 15);
    commit(3);
    wait_idle();
    do_reset();
    wr(12, 12); wr(14, 14);
    commit(3);
    wait_idle();
    sweep(3);

    // reset mid-CHECK aborts the commit silently
    wr(0, 1); wr(24, 17);
    commit(0);
    repeat (10) cycle();
    do_reset();
    repeat (30) cycle();
    sweep(0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      in_valid   = ($urandom % 4) != 0;
      data_in    = 5'($urandom_range(0, 31));
      bank_sel   = 2'($urandom_range(0, 3));
      out_ready  = ($urandom % 3) != 0;
      cfg_wr     = ($urandom % 4) == 0;
      cfg_a      = 5'($urandom_range(0, 27));
      cfg_b      = 5'($urandom_range(0, 27));
      cfg_commit = ($urandom % 40) == 0;
      cfg_bank   = 2'($urandom_range(0, 3));
      cycle();
    end
    idle_inputs();
    wait_idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
